// File: rtl/iterative_shifter.sv
// Multi-cycle shift/rotate unit: accepts one operation over a valid/ready
// handshake, walks it in StepLarge-bit strides and then single-bit strides,
// and returns the result over a second valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operation handshake (in_ready high only in IDLE)
//   in_data              operand
//   in_amount            shift/rotate amount
//   in_left1_right0      direction
//   in_arith1_logic0     arithmetic fill (right shifts only)
//   in_shift1_rotate0    shift vs rotate
//   out_valid/out_ready  result handshake
//   out_data             result, held stable while out_valid is high
module iterative_shifter #(
  parameter int unsigned BitWidth  = 32,
  parameter int unsigned StepLarge = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BitWidth-1:0]         in_data,
  input  logic [$clog2(BitWidth)-1:0] in_amount,
  input  logic                        in_left1_right0,
  input  logic                        in_arith1_logic0,
  input  logic                        in_shift1_rotate0,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BitWidth-1:0]         out_data
);

  localparam int unsigned AmtW = $clog2(BitWidth);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [BitWidth-1:0] data_q, data_d;
  logic [BitWidth-1:0] out_data_q, out_data_d;
  logic [AmtW-1:0]     remaining_q, remaining_d;
  logic                left_q, left_d;
  logic                shift_q, shift_d;
  logic                fill_q, fill_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic                big_step;
  logic [AmtW-1:0]     step_amt;
  logic [BitWidth-1:0] step_val;

  // One iteration of the datapath; only two fixed strides, so no barrel logic.
  always_comb begin
    big_step = (remaining_q >= AmtW'(StepLarge));
    step_amt = big_step ? AmtW'(StepLarge) : AmtW'(1);
    if (big_step) begin
      if (!shift_q && left_q)
        step_val = {data_q[BitWidth-StepLarge-1:0], data_q[BitWidth-1:BitWidth-StepLarge]};
      else if (!shift_q)
        step_val = {data_q[StepLarge-1:0], data_q[BitWidth-1:StepLarge]};
      else if (left_q)
        step_val = {data_q[BitWidth-StepLarge-1:0], {StepLarge{1'b0}}};
      else
        step_val = {{StepLarge{fill_q}}, data_q[BitWidth-1:StepLarge]};
    end else begin
      if (!shift_q && left_q)
        step_val = {data_q[BitWidth-2:0], data_q[BitWidth-1]};
      else if (!shift_q)
        step_val = {data_q[0], data_q[BitWidth-1:1]};
      else if (left_q)
        step_val = {data_q[BitWidth-2:0], 1'b0};
      else
        step_val = {fill_q, data_q[BitWidth-1:1]};
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    out_data_d  = out_data_q;
    remaining_d = remaining_q;
    left_d      = left_q;
    shift_d     = shift_q;
    fill_d      = fill_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d      = in_data;
          remaining_d = in_amount;
          left_d      = in_left1_right0;
          shift_d     = in_shift1_rotate0;
          // Sign fill only matters for arithmetic right shifts; zero otherwise.
          fill_d      = in_data[BitWidth-1] & in_arith1_logic0 &
                        ~in_left1_right0 & in_shift1_rotate0;
          if (in_amount == '0) begin
            out_data_d = in_data;
            state_d    = DONE;
          end else begin
            state_d    = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d      = step_val;
        remaining_d = remaining_q - step_amt;
        if (remaining_q == step_amt) begin
          out_data_d = step_val;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      out_data_q  <= '0;
      remaining_q <= '0;
      left_q      <= 1'b0;
      shift_q     <= 1'b0;
      fill_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      remaining_q <= remaining_d;
      left_q      <= left_d;
      shift_q     <= shift_d;
      fill_q      <= fill_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_iterative_shifter.sv
module tb_iterative_shifter;

  localparam int unsigned BW = 32;
  localparam int unsigned SL = 4;
  localparam int unsigned AW = $clog2(BW);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic [AW-1:0] in_amount;
  logic          in_left1_right0;
  logic          in_arith1_logic0;
  logic          in_shift1_rotate0;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;

  int checks = 0;
  int errors = 0;

  iterative_shifter #(.BitWidth(BW), .StepLarge(SL)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_amount         (in_amount),
    .in_left1_right0   (in_left1_right0),
    .in_arith1_logic0  (in_arith1_logic0),
    .in_shift1_rotate0 (in_shift1_rotate0),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data)
  );

  always #5 clk = ~clk;

  // Behavioural reference: the whole operation in one arithmetic expression.
  function automatic logic [BW-1:0] ref_model(input logic [BW-1:0] d, input int a,
                                              input bit l, input bit ar, input bit s);
    logic signed [BW-1:0] sd;
    sd = d;
    if (s) begin
      if (l)       return d << a;
      else if (ar) return sd >>> a;
      else         return d >> a;
    end
    if (a == 0) return d;
    if (l) return (d << a) | (d >> (BW - a));
    return (d >> a) | (d << (BW - a));
  endfunction

  // Edges from the accepting edge (inclusive) until out_valid is seen.
  function automatic int ref_latency(input int a);
    return a / SL + a % SL + 1;
  endfunction

  task automatic scramble();
    in_data           = $urandom;
    in_amount         = AW'($urandom);
    in_left1_right0   = 1'($urandom);
    in_arith1_logic0  = 1'($urandom);
    in_shift1_rotate0 = 1'($urandom);
  endtask

  // Runs one operation, holds out_ready low for 'hold' cycles, then drains it.
  task automatic do_op(input logic [BW-1:0] d, input int a, input bit l, input bit ar,
                       input bit s, input int hold, input string name);
    logic [BW-1:0] exp_data;
    int            lat;
    exp_data = ref_model(d, a, l, ar, s);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before: got %b want 1", name, in_ready);
    end
    in_data = d; in_amount = AW'(a); in_left1_right0 = l;
    in_arith1_logic0 = ar; in_shift1_rotate0 = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL %s busy_ready: got %b want 0 at edge %0d", name, in_ready, lat);
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != ref_latency(a)) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, ref_latency(a));
    end
    checks++;
    if (out_data !== exp_data) begin
      errors++; $display("FAIL %s data: got %h want %h", name, out_data, exp_data);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_data || in_ready !== 1'b0) begin
        errors++; $display("FAIL %s hold: valid %b data %h ready %b want 1 %h 0",
                           name, out_valid, out_data, in_ready, exp_data);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s drain: valid %b ready %b want 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; scramble();
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL reset: valid %b data %h want 0 0", out_valid, out_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready %b valid %b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    do_op(32'h8000_0000, 31, 0, 0, 1, 0, "srl31");
    do_op(32'h8000_0000,  4, 0, 1, 1, 0, "sra4");
    do_op(32'h7000_0000,  5, 0, 1, 1, 0, "sra5_pos");
    do_op(32'h8000_0001,  1, 1, 0, 0, 0, "rol1");
    do_op(32'h8000_0001,  1, 1, 1, 0, 0, "rol1_arith");
    do_op(32'h0000_00F1,  4, 0, 0, 0, 0, "ror4");
    do_op(32'h8000_00F1,  7, 0, 1, 0, 0, "ror7_arith");
    do_op(32'h1234_5678,  0, 1, 0, 1, 0, "sll0");
    do_op(32'h1234_5678,  8, 1, 0, 1, 0, "sll8");
    do_op(32'hF000_0000,  9, 1, 1, 1, 0, "sll9_arith");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      do_op($urandom, int'($urandom_range(BW - 1, 0)), 1'($urandom), 1'($urandom),
            1'($urandom), int'($urandom_range(2, 0)), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] held;
    do_op(32'hDEAD_BEEF, 0, 1, 0, 1, 0, "pre_bp");
    in_data = 32'hCAFE_F00D; in_amount = AW'(12); in_left1_right0 = 1'b0;
    in_arith1_logic0 = 1'b1; in_shift1_rotate0 = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && checks < 100000) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1) checks++;
      if (checks > 50000) break;
    end
    held = ref_model(32'hCAFE_F00D, 12, 0, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== held) begin
      errors++; $display("FAIL bp_result: valid %b data %h want 1 %h", out_valid, out_data, held);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_data = $urandom; in_amount = AW'(0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold: valid %b data %h ready %b want 1 %h 0",
                           out_valid, out_data, in_ready, held);
      end
    end
    // Release together with a new request: it must not be taken on the same edge.
    out_ready = 1'b1;
    in_data = 32'h0000_0F0F; in_amount = AW'(6); in_left1_right0 = 1'b1;
    in_arith1_logic0 = 1'b0; in_shift1_rotate0 = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle: valid %b ready %b want 0 1", out_valid, in_ready);
    end
    do_op(32'h0000_0F0F, 6, 1, 0, 0, 0, "b2b_op");
  endtask

  task automatic test_reset_mid_shift();
    in_data = 32'h8000_0000; in_amount = AW'(31); in_left1_right0 = 1'b0;
    in_arith1_logic0 = 1'b0; in_shift1_rotate0 = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL rst_mid: valid %b data %h want 0 0", out_valid, out_data);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL rst_mid_release: ready %b valid %b data %h want 1 0 0",
                         in_ready, out_valid, out_data);
    end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL rst_abort: valid %b ready %b want 0 1", out_valid, in_ready);
      end
    end
    do_op(32'h0000_0001, 31, 1, 0, 1, 0, "sll31_after_rst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
